// File: rtl/alu_issue_ctrl.sv
// Issue-side scoreboard for the ALU: holds one decoded instruction, tracks the
// producer of every architectural register and issues with data or forwarding tags.
module alu_issue_ctrl #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [4:0]       dec_rd,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic             dec_use_imm,
  input  logic [31:0]      dec_imm,
  input  logic [5:0]       dec_ex_type,
  output logic [4:0]       rf_raddr1,
  output logic [4:0]       rf_raddr2,
  input  logic [31:0]      rf_rdata1,
  input  logic [31:0]      rf_rdata2,
  input  logic [1:0]       alu_state,
  output logic             alu_load,
  output logic [4:0]       alu_rd,
  output logic [32:0]      alu_data1,
  output logic [32:0]      alu_data2,
  output logic [5:0]       alu_ex_type,
  output logic [1:0]       alu_data1_depend,
  output logic [1:0]       alu_data2_depend,
  input  logic             alu_done,
  input  logic [4:0]       alu_rd_out,
  input  logic             mul_wb_valid,
  input  logic [4:0]       mul_wb_rd,
  input  logic             lsu_wb_valid,
  input  logic [4:0]       lsu_wb_rd,
  input  logic             mark_valid,
  input  logic [4:0]       mark_rd,
  input  logic [1:0]       mark_tag,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] TAG_NONE = 2'b00;
  localparam logic [1:0] TAG_ALU  = 2'b01;
  localparam logic [1:0] TAG_MUL  = 2'b10;
  localparam logic [1:0] TAG_LSU  = 2'b11;

  typedef enum logic {EMPTY, HELD} state_t;

  state_t      state;
  logic [1:0]  status [NUM_REGS];
  logic [4:0]  rd_p0, rs1_p0, rs2_p0;
  logic        use_imm_p0;
  logic [31:0] imm_p0;
  logic [5:0]  ex_type_p0;

  logic        held, src1_ok, src2_ok, waw_ok, issue_ok;
  logic [34:0] opnd1, opnd2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Returns {depend, valid, data}; x0 always reads as a ready zero.
  function automatic logic [34:0] build_opnd(input logic [4:0] rs, input logic [1:0] tag,
                                             input logic [31:0] rdata);
    if (rs == 5'd0)
      return {TAG_NONE, 1'b1, 32'd0};
    else if (tag == TAG_NONE)
      return {TAG_NONE, 1'b1, rdata};
    else
      return {tag, 33'd0};
  endfunction

  assign held     = (state == HELD);
  assign src1_ok  = (rs1_p0 == 5'd0) || (status[rs1_p0] != TAG_ALU);
  assign src2_ok  = use_imm_p0 || (rs2_p0 == 5'd0) || (status[rs2_p0] != TAG_ALU);
  assign waw_ok   = (rd_p0 == 5'd0) || (status[rd_p0] == TAG_NONE);
  assign issue_ok = held && (alu_state == 2'b00) && src1_ok && src2_ok && waw_ok;
  assign alu_load = issue_ok;

  assign rf_raddr1 = held ? rs1_p0 : 5'd0;
  assign rf_raddr2 = held ? rs2_p0 : 5'd0;

  assign opnd1 = build_opnd(rs1_p0, status[rs1_p0], rf_rdata1);
  assign opnd2 = build_opnd(rs2_p0, status[rs2_p0], rf_rdata2);

  // p0: decode hand-off into the holding register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      dec_ready <= 1'b1;
      stall_cnt <= '0;
    end else begin
      if (held && !issue_ok)
        stall_cnt <= sat_inc(stall_cnt);
      case (state)
        EMPTY: if (dec_valid && !flush) begin
          state     <= HELD;
          dec_ready <= 1'b0;
        end
        HELD: if (issue_ok || flush) begin
          state     <= EMPTY;
          dec_ready <= 1'b1;
        end
        default: begin
          state     <= EMPTY;
          dec_ready <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == EMPTY && dec_valid && !flush) begin
      rd_p0      <= dec_rd;
      rs1_p0     <= dec_rs1;
      rs2_p0     <= dec_rs2;
      use_imm_p0 <= dec_use_imm;
      imm_p0     <= dec_imm;
      ex_type_p0 <= dec_ex_type;
    end
  end

  // Producer table: own issue beats external mark beats a tag-matching writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        status[i] <= TAG_NONE;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (issue_ok && rd_p0 == 5'(i))
          status[i] <= TAG_ALU;
        else if (mark_valid && mark_rd == 5'(i) && mark_tag[1])
          status[i] <= mark_tag;
        else if ((alu_done     && alu_rd_out == 5'(i) && status[i] == TAG_ALU) ||
                 (mul_wb_valid && mul_wb_rd  == 5'(i) && status[i] == TAG_MUL) ||
                 (lsu_wb_valid && lsu_wb_rd  == 5'(i) && status[i] == TAG_LSU))
          status[i] <= TAG_NONE;
      end
    end
  end

  // p1: issue strobe toward the ALU, zeroed when not loading
  always_comb begin
    alu_rd           = 5'd0;
    alu_ex_type      = 6'd0;
    alu_data1        = 33'd0;
    alu_data2        = 33'd0;
    alu_data1_depend = TAG_NONE;
    alu_data2_depend = TAG_NONE;
    if (issue_ok) begin
      alu_rd      = rd_p0;
      alu_ex_type = ex_type_p0;
      {alu_data1_depend, alu_data1} = opnd1;
      if (use_imm_p0) begin
        alu_data2_depend = TAG_NONE;
        alu_data2        = {1'b1, imm_p0};
      end else begin
        {alu_data2_depend, alu_data2} = opnd2;
      end
    end
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Issue-side scoreboard controller that drives the ALU functional unit's load interface.
- Holds one decoded ALU instruction and tracks a per-register producer table (none/ALU/MUL/LSU).
- Resolves RAW and WAW hazards, and issues with operand data or producer-forwarding tags.
- Consumes ALU/MUL/LSU writeback events to retire pending registers.

Parameters:
NUM_REGS, 32, architectural registers; x0 is hard-wired zero.
CNT_W, 32, width of stall counter.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
dec_valid  in  1  decoded ALU instruction valid
dec_ready  out  1  holding register empty; accept when dec_valid&dec_ready
dec_rd  in  5  destination register
dec_rs1  in  5  source 1 register
dec_rs2  in  5  source 2 register
dec_use_imm  in  1  source 2 is dec_imm, not rs2
dec_imm  in  32  immediate
dec_ex_type  in  6  ALU op code (0..20)
rf_raddr1  out  5  regfile read address 1 (= held rs1)
rf_raddr2  out  5  regfile read address 2 (= held rs2)
rf_rdata1  in  32  regfile read data 1 (combinational)
rf_rdata2  in  32  regfile read data 2
alu_state  in  2  ALU state: 00 ready, 01 busy, 10 done
alu_load  out  1  one-cycle issue strobe
alu_rd  out  5  issued rd
alu_data1  out  33  {valid,data} operand 1
alu_data2  out  33  {valid,data} operand 2
alu_ex_type  out  6  issued op
alu_data1_depend  out  2  00 data, 10 MUL, 11 LSU
alu_data2_depend  out  2  same encoding
alu_done  in  1  ALU writeback strobe
alu_rd_out  in  5  ALU writeback rd
mul_wb_valid  in  1  MUL result broadcast (mul_data[32])
mul_wb_rd  in  5  MUL writeback rd
lsu_wb_valid  in  1  LSU result broadcast (lsu_data[32])
lsu_wb_rd  in  5  LSU writeback rd
mark_valid  in  1  external MUL/LSU issue marks a register pending
mark_rd  in  5  register to mark
mark_tag  in  2  10 MUL, 11 LSU
flush  in  1  discard held instruction
stall_cnt  out  CNT_W  cycles with held instruction not issued

Behaviour:
- **Reset:**
  - Status table all 00, hold empty, dec_ready=1, stall_cnt=0.
  - All alu_* outputs are 0 whenever alu_load=0.
  - Reset mid-operation drops the held instruction and all pending marks.
- **States:** EMPTY and HELD (hold_valid flag).
  - EMPTY: dec_ready=1. On dec_valid the instruction is latched and the state goes to HELD.
  - HELD: dec_ready=0. issue_ok = (alu_state==00) & rs1 not tag 01 & (dec_use_imm | rs2 not tag 01) & status[rd]==00 (WAW).
  - Register x0 is exempt from all hazard checks.
  - When issue_ok: alu_load=1 for that cycle (combinational). At the edge, hold→EMPTY and status[rd]←01 (unless rd=0).
  - Otherwise stall_cnt increments; it saturates at all-ones.
- **Minimum spacing:** accept at edge N, issue in cycle N+1, next accept at edge N+2. Back-to-back ALU ops are additionally gated by alu_state.
- **Operand build (per source):**
  - Tag 00 or rs=0: data={1,rf_rdata} (x0 gives {1,0}), depend 00.
  - Tag 10: data=33'd0, depend 10. Tag 11: data=33'd0, depend 11.
  - Tag 01 never issues.
  - dec_use_imm: data2={1,imm}, depend 00.
- **Status uses registered table only.** A MUL/LSU writeback in the issue cycle still issues with depend tag; the ALU captures the broadcast on load.
- **Table update priority per register, highest first:**
  1. Issue mark 01.
  2. mark_valid mark.
  3. Writeback clear.
- **Clear conditions:** clear only if the current tag matches the producer: alu_done&tag01, mul_wb_valid&tag10, lsu_wb_valid&tag11. A mismatched writeback is ignored.
- **Marks to x0 are ignored.** mark_tag 00/01 are ignored.
- **flush:**
  - Clears hold in the same edge. An issue already strobed that cycle is still completed.
  - Table is untouched; flush has priority over a new accept.
- **ALU register visibility:** ALU-produced registers become readable the cycle after alu_done. The regfile writes at that edge.

Test Plan:
- Reset; addi x1,x0,5 (ex_type 1) → alu_load 1 cycle later, data1={1,0}, data2={1,5}, depend 00/00, status[x1]=01.
- add x2,x1,x1 right after addi x1 → held, stall_cnt counts while ALU busy/done. After alu_done rd_out=1, issues next cycle with rf_rdata1=5. Status[x1]=00, status[x2]=01.
- mark x3 MUL; sub x4,x3,x0 → issues immediately, data1=33'd0, depend1=10. A mul_wb_valid rd=3 in the same cycle still gives depend 10, then status[x3]=00.
- mark x5 LSU; addi x5,x0,1 → WAW stall until lsu_wb_valid rd=5, then issue. A mul_wb_valid rd=5 earlier does not clear.
- Same cycle mark_valid x6 MUL and lsu_wb_valid rd=6 with prior tag 11 → tag ends 10.
- Hold instruction stalled on x1; assert flush → dec_ready=1 next cycle, no alu_load. Assert rst mid-stall → all outputs/table zero.
